// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream boot loader driving the core program-load port.
// Frame is LEN(4) | DATA(N*4) | CHK(1); start is released only after a clean checksum.
module prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        prog_en,
    output logic [31:0] prog_addr,
    output logic [31:0] prog_data,
    output logic        start,
    output logic        busy,
    output logic        error
);
    localparam int WW = $clog2(MAX_WORDS + 1);
    localparam logic [2:0] LEN  = 3'd0;
    localparam logic [2:0] DATA = 3'd1;
    localparam logic [2:0] CHK  = 3'd2;
    localparam logic [2:0] RUN  = 3'd3;
    localparam logic [2:0] ERR  = 3'd4;

    logic [2:0]    state;
    logic          alive;
    logic [1:0]    byte_cnt;
    logic [31:0]   len;
    logic [31:0]   word_buf;
    logic [WW-1:0] word_idx;
    logic [7:0]    chk;
    logic          xfer;
    logic [31:0]   len_next;
    logic [31:0]   word_next;

    // alive keeps in_ready low until the first clock after reset deasserts
    assign in_ready  = alive && (state == LEN || state == DATA || state == CHK);
    assign xfer      = in_valid && in_ready;
    assign len_next  = {in_data, len[31:8]};
    assign word_next = {in_data, word_buf[31:8]};
    assign start     = state == RUN;
    assign error     = state == ERR;
    assign busy      = (state == LEN && byte_cnt != 2'd0) || state == DATA || state == CHK;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LEN;
            alive     <= 1'b0;
            byte_cnt  <= 2'd0;
            len       <= 32'd0;
            word_buf  <= 32'd0;
            word_idx  <= '0;
            chk       <= 8'd0;
            prog_en   <= 1'b0;
            prog_addr <= 32'd0;
            prog_data <= 32'd0;
        end else begin
            alive   <= 1'b1;
            prog_en <= 1'b0;
            if (xfer) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (state)
                    LEN: begin
                        len <= len_next;
                        if (byte_cnt == 2'd3) begin
                            state    <= (len_next == 32'd0 || len_next > 32'(MAX_WORDS)) ? ERR : DATA;
                            word_idx <= '0;
                            chk      <= 8'd0;
                        end
                    end
                    DATA: begin
                        word_buf <= word_next;
                        chk      <= chk ^ in_data;
                        if (byte_cnt == 2'd3) begin
                            prog_en   <= 1'b1;
                            prog_data <= word_next;
                            prog_addr <= BASE_ADDR + (32'(word_idx) << 2);
                            word_idx  <= word_idx + 1'b1;
                            if (32'(word_idx) + 32'd1 == len)
                                state <= CHK;
                        end
                    end
                    CHK:     state <= (in_data == chk) ? RUN : ERR;
                    default: state <= state;
                endcase
            end
        end
    end
endmodule
